// File: rtl/ahb_system_top.sv
// Single-master AHB-Lite demo subsystem: master FSM, registered arbiter, slave-index
// decoder and four zero-wait slaves, with one transfer launched per external request.
module ahb_system_top #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int NUM_SLAVES = 4
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [1:0]        ext_slv_sel_in,
  input  logic [DATA_W-1:0] ext_mast_din,
  input  logic              ext_wr,
  input  logic              ext_enable,
  input  logic              ext_hbusreq_in,
  input  logic [DATA_W-1:0] ext_slave_din,
  output logic [DATA_W-1:0] ext_mast_dout,
  output logic [ADDR_W-1:0] ext_addr_out,
  output logic [DATA_W-1:0] ext_slave_dout,
  output logic              ext_hwrite_out
);

  localparam int SEL_W = 2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_ADDR = 2'd2;
  localparam logic [1:0] S_DATA = 2'd3;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  logic [1:0]        r_state;
  logic              r_hbusreq;
  logic              r_hgrant;
  logic [ADDR_W-1:0] r_haddr;
  logic              r_hwrite;
  logic [SEL_W-1:0]  r_sel;
  logic [DATA_W-1:0] r_mast_dout;

  logic              w_req_on;
  logic [1:0]        w_htrans;
  logic [ADDR_W-1:0] w_haddr;
  logic              w_hwrite;
  logic [SEL_W-1:0]  w_sel;
  logic [DATA_W-1:0] w_hwdata;
  logic [DATA_W-1:0] w_hrdata;
  logic              w_hready;
  logic [NUM_SLAVES-1:0] w_hsel;

  logic [NUM_SLAVES-1:0] w_slv_hready;
  logic [DATA_W-1:0]     w_slv_hrdata [NUM_SLAVES];
  logic [DATA_W-1:0]     w_slv_reg    [NUM_SLAVES];

  assign w_req_on = ext_enable && ext_hbusreq_in;

  // Address-phase signals are live from ext_* during ADDR and held from the latches otherwise.
  always_comb begin
    w_htrans = HTRANS_IDLE;
    w_haddr  = r_haddr;
    w_hwrite = r_hwrite;
    w_sel    = r_sel;
    w_hwdata = '0;
    if (r_state == S_ADDR) begin
      w_htrans = HTRANS_NONSEQ;
      w_haddr  = ext_addr;
      w_hwrite = ext_wr;
      w_sel    = ext_slv_sel_in;
    end
    if (r_state == S_DATA) begin
      w_hwdata = ext_mast_din;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      w_hsel[i] = (w_sel == SEL_W'(i));
    end
  end

  assign w_hready = w_slv_hready[r_sel];
  assign w_hrdata = w_slv_hrdata[r_sel];

  always_ff @(posedge hclk or posedge hresetn) begin
    if (hresetn) begin
      r_hgrant <= 1'b0;
    end else begin
      r_hgrant <= r_hbusreq;
    end
  end

  always_ff @(posedge hclk or posedge hresetn) begin
    if (hresetn) begin
      r_state     <= S_IDLE;
      r_hbusreq   <= 1'b0;
      r_haddr     <= '0;
      r_hwrite    <= 1'b0;
      r_sel       <= '0;
      r_mast_dout <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req_on) begin
            r_state   <= S_REQ;
            r_hbusreq <= 1'b1;
          end
        end
        S_REQ: begin
          if (r_hgrant) begin
            r_state <= S_ADDR;
          end else if (!w_req_on) begin
            r_state   <= S_IDLE;
            r_hbusreq <= 1'b0;
          end
        end
        S_ADDR: begin
          r_haddr  <= ext_addr;
          r_hwrite <= ext_wr;
          r_sel    <= ext_slv_sel_in;
          r_state  <= S_DATA;
        end
        default: begin
          if (w_hready) begin
            if (!r_hwrite) begin
              r_mast_dout <= w_hrdata;
            end
            if (w_req_on && r_hgrant) begin
              r_state <= S_ADDR;
            end else begin
              r_state   <= S_IDLE;
              r_hbusreq <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_slv
    logic              r_wr_pend;
    logic [DATA_W-1:0] r_wdata;

    assign w_slv_hready[g] = 1'b1;
    assign w_slv_hrdata[g] = ext_slave_din;
    assign w_slv_reg[g]    = r_wdata;

    // A write captured in the address phase lands at the end of the following data phase.
    always_ff @(posedge hclk or posedge hresetn) begin
      if (hresetn) begin
        r_wr_pend <= 1'b0;
        r_wdata   <= '0;
      end else if (w_hready) begin
        if (r_wr_pend) begin
          r_wdata <= w_hwdata;
        end
        r_wr_pend <= w_hsel[g] && (w_htrans == HTRANS_NONSEQ) && w_hwrite;
      end
    end
  end

  assign ext_mast_dout  = r_mast_dout;
  assign ext_addr_out   = w_haddr;
  assign ext_hwrite_out = w_hwrite;
  assign ext_slave_dout = w_slv_reg[ext_slv_sel_in];

endmodule

// File: tb/tb_ahb_system_top.sv
// Randomized bench for ahb_system_top checked against a transaction-level model
// (slave register array, last address/direction, last read data).
module tb_ahb_system_top;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic [31:0] ext_addr;
  logic [1:0]  ext_slv_sel_in;
  logic [31:0] ext_mast_din;
  logic        ext_wr;
  logic        ext_enable;
  logic        ext_hbusreq_in;
  logic [31:0] ext_slave_din;
  logic [31:0] ext_mast_dout;
  logic [31:0] ext_addr_out;
  logic [31:0] ext_slave_dout;
  logic        ext_hwrite_out;

  int unsigned n_chk = 0;
  int unsigned n_bad = 0;

  logic [31:0] m_slv [4];
  logic [31:0] m_mdout;
  logic [31:0] m_addr;
  logic        m_wr;

  ahb_system_top #(.DATA_W(32), .ADDR_W(32), .NUM_SLAVES(4)) dut (
    .hclk           (hclk),
    .hresetn        (hresetn),
    .ext_addr       (ext_addr),
    .ext_slv_sel_in (ext_slv_sel_in),
    .ext_mast_din   (ext_mast_din),
    .ext_wr         (ext_wr),
    .ext_enable     (ext_enable),
    .ext_hbusreq_in (ext_hbusreq_in),
    .ext_slave_din  (ext_slave_din),
    .ext_mast_dout  (ext_mast_dout),
    .ext_addr_out   (ext_addr_out),
    .ext_slave_dout (ext_slave_dout),
    .ext_hwrite_out (ext_hwrite_out)
  );

  always #5 hclk = ~hclk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_slv[i] = '0;
    m_mdout = '0;
    m_addr  = '0;
    m_wr    = 1'b0;
  endtask

  // A transfer completes: writes land in the selected slave, reads update the master's copy.
  task automatic model_xfer(input logic [31:0] a, input logic [1:0] s, input logic w,
                            input logic [31:0] wd, input logic [31:0] rd);
    m_addr = a;
    m_wr   = w;
    if (w) m_slv[s] = wd;
    else   m_mdout  = rd;
  endtask

  task automatic check_all(input string tag);
    logic [1:0] keep;
    keep = ext_slv_sel_in;
    check_val({tag, ".mdout"}, ext_mast_dout, m_mdout);
    check_val({tag, ".addr"}, ext_addr_out, m_addr);
    check_val({tag, ".hwrite"}, {31'd0, ext_hwrite_out}, {31'd0, m_wr});
    for (int s = 0; s < 4; s++) begin
      ext_slv_sel_in = 2'(s);
      #1;
      check_val($sformatf("%s.slv%0d", tag, s), ext_slave_dout, m_slv[s]);
    end
    ext_slv_sel_in = keep;
  endtask

  // Single transfer with request held through the grant, then dropped; completion at edge 5.
  task automatic do_xfer(input string tag, input logic [31:0] a, input logic [1:0] s,
                         input logic w, input logic [31:0] wd, input logic [31:0] rd);
    ext_addr = a; ext_slv_sel_in = s; ext_wr = w; ext_mast_din = wd; ext_slave_din = rd;
    ext_enable = 1'b1; ext_hbusreq_in = 1'b1;
    tick(); tick(); tick();
    check_val({tag, ".e3_addr_hold"}, ext_mast_dout, m_mdout);
    ext_enable = 1'b0; ext_hbusreq_in = 1'b0;
    tick();
    check_val({tag, ".e4_mdout_hold"}, ext_mast_dout, m_mdout);
    check_val({tag, ".e4_slv_hold"}, ext_slave_dout, m_slv[s]);
    tick();
    model_xfer(a, s, w, wd, rd);
    check_all(tag);
    tick();
  endtask

  initial begin
    ext_addr = '0; ext_slv_sel_in = '0; ext_mast_din = '0; ext_wr = 1'b0;
    ext_enable = 1'b0; ext_hbusreq_in = 1'b0; ext_slave_din = '0;
    hresetn = 1'b1;
    model_reset();
    tick(); tick();
    hresetn = 1'b0;
    check_all("reset");

    // Idle with enable low: random other inputs must not start anything.
    for (int c = 0; c < 40; c++) begin
      ext_addr = $urandom; ext_wr = 1'($urandom); ext_mast_din = $urandom;
      ext_slave_din = $urandom; ext_hbusreq_in = 1'($urandom);
      tick();
      if (c % 10 == 9) check_all("idle");
    end
    ext_hbusreq_in = 1'b0;

    do_xfer("wr_dead", 32'h10, 2'd2, 1'b1, 32'hDEADBEEF, 32'h0);
    do_xfer("rd_1234", 32'h24, 2'd1, 1'b0, 32'h0, 32'h12345678);

    for (int t = 0; t < 12; t++) begin
      do_xfer("rand", $urandom, 2'($urandom), 1'($urandom), $urandom, $urandom);
    end

    // Back-to-back: one transfer every 2 cycles while enable/request stay high.
    ext_enable = 1'b1; ext_hbusreq_in = 1'b1;
    tick(); tick(); tick();
    for (int k = 0; k < 10; k++) begin
      logic [31:0] a, wd, rd;
      logic [1:0]  s;
      logic        w;
      a = $urandom; wd = $urandom; rd = $urandom; s = 2'($urandom); w = 1'($urandom);
      if (k < 3) begin a = '0; w = 1'b0; rd = '0; end
      ext_addr = a; ext_slv_sel_in = s; ext_wr = w; ext_mast_din = wd; ext_slave_din = rd;
      tick();
      if (k == 9) begin ext_enable = 1'b0; ext_hbusreq_in = 1'b0; end
      tick();
      model_xfer(a, s, w, wd, rd);
      check_all("b2b");
    end
    tick(); tick();
    check_all("b2b_end");

    // Reset while a write is in its data phase.
    ext_addr = 32'h40; ext_slv_sel_in = 2'd3; ext_wr = 1'b1; ext_mast_din = 32'hA5A5_5A5A;
    ext_enable = 1'b1; ext_hbusreq_in = 1'b1;
    tick(); tick(); tick();
    ext_enable = 1'b0; ext_hbusreq_in = 1'b0;
    tick();
    hresetn = 1'b1;
    #1;
    model_reset();
    check_all("rst_data");
    tick();
    hresetn = 1'b0;
    tick(); tick();
    check_all("rst_after");

    do_xfer("pre_drop", 32'h77, 2'd0, 1'b1, 32'h1357_9BDF, 32'h0);

    // Request withdrawn before grant: no address phase happens.
    ext_addr = 32'hFFFF_0000; ext_slv_sel_in = 2'd1; ext_wr = 1'b0; ext_slave_din = 32'hCAFE;
    ext_enable = 1'b1; ext_hbusreq_in = 1'b1;
    tick();
    ext_hbusreq_in = 1'b0;
    for (int c = 0; c < 6; c++) tick();
    check_all("req_drop");

    do_xfer("post_drop", 32'h88, 2'd1, 1'b0, 32'h0, 32'h2468_ACE0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
